// File: rtl/toll_booth_controller.sv
`default_nettype none
// ============================================================================
// Module   : toll_booth_controller
// Brief    : Per-lane toll sequencer wrapped around the rate classifier:
//            latches vehicle attributes, classifies, collects coins, returns
//            change, pulses the barrier gate and counts paid vehicles.
// Revision : 1.0 - initial release
// ============================================================================
module toll_booth_controller #(
    parameter int FEE_HIGH    = 200,
    parameter int FEE_MED     = 100,
    parameter int FEE_LOW     = 50,
    parameter int SETTLE      = 2,
    parameter int GATE_CYCLES = 8,
    parameter int TIMEOUT     = 64,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CarIn,
    input  logic             WD,
    input  logic             RH,
    input  logic             LN,
    input  logic             HT,
    input  logic             Coin,
    input  logic [7:0]       CoinVal,
    input  logic             Clear,
    input  logic             High,
    input  logic             Med,
    input  logic             Low,
    input  logic             Err,
    output logic             AWD,
    output logic             ARH,
    output logic             ALN,
    output logic             AHT,
    output logic [9:0]       Fee,
    output logic [9:0]       Change,
    output logic             GateOpen,
    output logic             Busy,
    output logic             Alarm,
    output logic [CNT_W-1:0] CarCount
);

    // One shared timer serves SETTLE, GATE and PAY; it only ever needs to hold
    // the largest terminal count minus one.
    localparam int c_TMR_MAX = (TIMEOUT > GATE_CYCLES)
                             ? ((TIMEOUT > SETTLE) ? TIMEOUT : SETTLE)
                             : ((GATE_CYCLES > SETTLE) ? GATE_CYCLES : SETTLE);
    localparam int c_TMR_W   = (c_TMR_MAX > 1) ? $clog2(c_TMR_MAX) : 1;

    localparam logic [c_TMR_W-1:0] c_TMR_ONE     = c_TMR_W'(1);
    localparam logic [c_TMR_W-1:0] c_SETTLE_LAST = c_TMR_W'(SETTLE - 1);
    localparam logic [c_TMR_W-1:0] c_GATE_LAST   = c_TMR_W'(GATE_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_TOUT_LAST   = c_TMR_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   c_CNT_ONE     = CNT_W'(1);

    localparam logic [9:0] c_FEE_HIGH = 10'(FEE_HIGH);
    localparam logic [9:0] c_FEE_MED  = 10'(FEE_MED);
    localparam logic [9:0] c_FEE_LOW  = 10'(FEE_LOW);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_SETTLE   = 3'd1;
    localparam logic [2:0] c_ST_CLASSIFY = 3'd2;
    localparam logic [2:0] c_ST_PAY      = 3'd3;
    localparam logic [2:0] c_ST_GATE     = 3'd4;
    localparam logic [2:0] c_ST_ALARM    = 3'd5;

    logic [2:0]         r_state,  w_state_nxt;
    logic [c_TMR_W-1:0] r_tmr,    w_tmr_nxt;
    logic [3:0]         r_attr,   w_attr_nxt;
    logic [9:0]         r_fee,    w_fee_nxt;
    logic [9:0]         r_credit, w_credit_nxt;
    logic [9:0]         r_change, w_change_nxt;
    logic [CNT_W-1:0]   r_count,  w_count_nxt;

    logic [10:0] w_credit_sum;
    logic [9:0]  w_credit_sat;

    assign w_credit_sum = {1'b0, r_credit} + {3'b000, CoinVal};
    assign w_credit_sat = w_credit_sum[10] ? 10'h3FF : w_credit_sum[9:0];

    always_comb begin
        w_state_nxt  = r_state;
        w_tmr_nxt    = r_tmr;
        w_attr_nxt   = r_attr;
        w_fee_nxt    = r_fee;
        w_credit_nxt = r_credit;
        w_change_nxt = r_change;
        w_count_nxt  = r_count;

        case (r_state)
            c_ST_IDLE: begin
                if (CarIn) begin
                    w_attr_nxt   = {WD, RH, LN, HT};
                    w_credit_nxt = '0;
                    w_tmr_nxt    = '0;
                    w_state_nxt  = c_ST_SETTLE;
                end
            end
            c_ST_SETTLE: begin
                if (r_tmr == c_SETTLE_LAST) begin
                    w_tmr_nxt   = '0;
                    w_state_nxt = c_ST_CLASSIFY;
                end else begin
                    w_tmr_nxt = r_tmr + c_TMR_ONE;
                end
            end
            c_ST_CLASSIFY: begin
                w_tmr_nxt = '0;
                if (Err || !(High || Med || Low)) begin
                    w_state_nxt = c_ST_ALARM;
                end else begin
                    w_fee_nxt   = High ? c_FEE_HIGH : (Med ? c_FEE_MED : c_FEE_LOW);
                    w_state_nxt = c_ST_PAY;
                end
            end
            c_ST_PAY: begin
                // A coin always wins over a timeout landing in the same cycle.
                if (Coin) begin
                    w_credit_nxt = w_credit_sat;
                    w_tmr_nxt    = '0;
                    if (w_credit_sat >= r_fee) begin
                        w_change_nxt = w_credit_sat - r_fee;
                        w_state_nxt  = c_ST_GATE;
                    end
                end else if (r_tmr == c_TOUT_LAST) begin
                    w_tmr_nxt   = '0;
                    w_fee_nxt   = '0;
                    w_state_nxt = c_ST_ALARM;
                end else begin
                    w_tmr_nxt = r_tmr + c_TMR_ONE;
                end
            end
            c_ST_GATE: begin
                if (r_tmr == c_GATE_LAST) begin
                    w_tmr_nxt    = '0;
                    w_count_nxt  = r_count + c_CNT_ONE;
                    w_change_nxt = '0;
                    w_fee_nxt    = '0;
                    w_credit_nxt = '0;
                    w_state_nxt  = c_ST_IDLE;
                end else begin
                    w_tmr_nxt = r_tmr + c_TMR_ONE;
                end
            end
            c_ST_ALARM: begin
                w_fee_nxt = '0;
                if (Clear) begin
                    w_credit_nxt = '0;
                    w_state_nxt  = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= c_ST_IDLE;
            r_tmr    <= '0;
            r_attr   <= '0;
            r_fee    <= '0;
            r_credit <= '0;
            r_change <= '0;
            r_count  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_tmr    <= w_tmr_nxt;
            r_attr   <= w_attr_nxt;
            r_fee    <= w_fee_nxt;
            r_credit <= w_credit_nxt;
            r_change <= w_change_nxt;
            r_count  <= w_count_nxt;
        end
    end

    assign {AWD, ARH, ALN, AHT} = r_attr;
    assign Fee      = r_fee;
    assign Change   = r_change;
    assign GateOpen = (r_state == c_ST_GATE);
    assign Busy     = (r_state != c_ST_IDLE);
    assign Alarm    = (r_state == c_ST_ALARM);
    assign CarCount = r_count;

endmodule
`default_nettype wire

// File: tb/tb_toll_booth_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_toll_booth_controller
// Brief    : Directed bench for the toll lane sequencer; a procedural lane
//            model predicts every output each cycle for two counter widths.
// Revision : 1.0 - initial release
// ============================================================================
module tb_toll_booth_controller;

    localparam int SETTLE      = 2;
    localparam int GATE_CYCLES = 8;
    localparam int TIMEOUT     = 64;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       CarIn = 1'b0, WD = 1'b0, RH = 1'b0, LN = 1'b0, HT = 1'b0;
    logic       Coin = 1'b0, Clear = 1'b0;
    logic [7:0] CoinVal = 8'd0;
    logic       High = 1'b0, Med = 1'b0, Low = 1'b0, Err = 1'b0;

    logic       AWD0, ARH0, ALN0, AHT0, Gate0, Busy0, Alarm0;
    logic [9:0] Fee0, Change0;
    logic [15:0] Cnt0;
    logic       AWD1, ARH1, ALN1, AHT1, Gate1, Busy1, Alarm1;
    logic [9:0] Fee1, Change1;
    logic [1:0] Cnt1;

    int n_vec = 0;
    int n_err = 0;

    toll_booth_controller u_dut (
        .CLK(CLK), .RST(RST), .CarIn(CarIn), .WD(WD), .RH(RH), .LN(LN), .HT(HT),
        .Coin(Coin), .CoinVal(CoinVal), .Clear(Clear),
        .High(High), .Med(Med), .Low(Low), .Err(Err),
        .AWD(AWD0), .ARH(ARH0), .ALN(ALN0), .AHT(AHT0),
        .Fee(Fee0), .Change(Change0), .GateOpen(Gate0), .Busy(Busy0),
        .Alarm(Alarm0), .CarCount(Cnt0)
    );

    toll_booth_controller #(.CNT_W(2)) u_dut_w2 (
        .CLK(CLK), .RST(RST), .CarIn(CarIn), .WD(WD), .RH(RH), .LN(LN), .HT(HT),
        .Coin(Coin), .CoinVal(CoinVal), .Clear(Clear),
        .High(High), .Med(Med), .Low(Low), .Err(Err),
        .AWD(AWD1), .ARH(ARH1), .ALN(ALN1), .AHT(AHT1),
        .Fee(Fee1), .Change(Change1), .GateOpen(Gate1), .Busy(Busy1),
        .Alarm(Alarm1), .CarCount(Cnt1)
    );

    always #5 CLK = ~CLK;

    // ---------------- lane model: one vehicle transaction per loop pass -----
    logic [3:0] m_a;
    int         m_fee, m_change, m_count;
    logic       m_gate, m_busy, m_alarm;

    task automatic m_reset();
        m_a = 4'd0; m_fee = 0; m_change = 0; m_count = 0;
        m_gate = 1'b0; m_busy = 1'b0; m_alarm = 1'b0;
    endtask

    task automatic tick(output bit ab);
        @(posedge CLK);
        ab = RST;
    endtask

    initial begin : p_model
        bit ab;
        bit to_alarm;
        bit paid;
        int credit, fee, timer;
        m_reset();
        forever begin
            m_fee = 0; m_change = 0; m_gate = 1'b0; m_busy = 1'b0; m_alarm = 1'b0;
            tick(ab);
            if (ab) begin m_reset(); continue; end
            if (!CarIn) continue;
            m_a = {WD, RH, LN, HT};
            m_busy = 1'b1;
            credit = 0;
            // settle window, then the edge on which the class is taken
            for (int i = 0; i < SETTLE + 1 && !ab; i++) tick(ab);
            if (ab) begin m_reset(); continue; end
            to_alarm = Err || !(High || Med || Low);
            paid = 1'b0;
            if (!to_alarm) begin
                fee = High ? 200 : (Med ? 100 : 50);
                m_fee = fee;
                timer = 0;
                while (!paid && !to_alarm) begin
                    tick(ab);
                    if (ab) break;
                    if (Coin) begin
                        credit = credit + int'(CoinVal);
                        if (credit > 1023) credit = 1023;
                        timer = 0;
                        paid = (credit >= fee);
                    end else begin
                        timer++;
                        to_alarm = (timer == TIMEOUT);
                    end
                end
                if (ab) begin m_reset(); continue; end
            end
            if (paid) begin
                m_gate = 1'b1;
                m_change = credit - fee;
                for (int i = 0; i < GATE_CYCLES && !ab; i++) tick(ab);
                if (ab) begin m_reset(); continue; end
                m_count++;
            end else begin
                m_fee = 0;
                m_alarm = 1'b1;
                do tick(ab); while (!ab && !Clear);
                if (ab) begin m_reset(); continue; end
            end
        end
    end

    // ---------------- per-cycle compare --------------------------------------
    function automatic logic [42:0] pk(input logic [3:0] a, input logic [9:0] f,
                                       input logic [9:0] c, input logic g,
                                       input logic b, input logic al,
                                       input logic [15:0] n);
        return {a, f, c, g, b, al, n};
    endfunction

    always @(negedge CLK) begin
        logic [42:0] e0, e1, a0, a1;
        if (RST) begin
            e0 = '0;
            e1 = '0;
        end else begin
            e0 = pk(m_a, 10'(m_fee), 10'(m_change), m_gate, m_busy, m_alarm, 16'(m_count));
            e1 = pk(m_a, 10'(m_fee), 10'(m_change), m_gate, m_busy, m_alarm, 16'(m_count % 4));
        end
        a0 = pk({AWD0, ARH0, ALN0, AHT0}, Fee0, Change0, Gate0, Busy0, Alarm0, Cnt0);
        a1 = pk({AWD1, ARH1, ALN1, AHT1}, Fee1, Change1, Gate1, Busy1, Alarm1, {14'd0, Cnt1});
        n_vec++;
        if (a0 !== e0) begin
            n_err++;
            $display("FAIL cycle_dut16 t=%0t got %h expected %h", $time, a0, e0);
        end
        n_vec++;
        if (a1 !== e1) begin
            n_err++;
            $display("FAIL cycle_dut2 t=%0t got %h expected %h", $time, a1, e1);
        end
    end

    // ---------------- directed stimulus --------------------------------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic cls(input logic h, input logic m, input logic l, input logic e);
        High = h; Med = m; Low = l; Err = e;
    endtask

    // Attributes are inverted after the pulse so the latched copy is exercised.
    task automatic car(input logic [3:0] at);
        {WD, RH, LN, HT} = at;
        CarIn = 1'b1;
        step();
        CarIn = 1'b0;
        {WD, RH, LN, HT} = ~at;
    endtask

    task automatic coin(input logic [7:0] v);
        Coin = 1'b1;
        CoinVal = v;
        step();
        Coin = 1'b0;
        CoinVal = 8'd0;
    endtask

    task automatic clear_pulse();
        Clear = 1'b1;
        step();
        Clear = 1'b0;
    endtask

    initial begin : p_stim
        idle(2);
        RST = 1'b0;
        chk("reset_busy", Busy0, 0);
        idle(2);

        // Low vehicle, exact payment in two coins
        cls(0, 0, 1, 0);
        car(4'b1100);
        idle(SETTLE + 1);
        chk("low_fee", Fee0, 50);
        coin(8'd25);
        chk("low_gate_closed", Gate0, 0);
        coin(8'd25);
        chk("low_gate_open", Gate0, 1);
        chk("low_change", Change0, 0);
        idle(GATE_CYCLES - 1);
        chk("low_gate_last", Gate0, 1);
        idle(1);
        chk("low_gate_done", Gate0, 0);
        chk("low_busy", Busy0, 0);
        chk("low_count", Cnt0, 1);
        idle(2);

        // High beats Low; overpay; CarIn and coin during GATE are ignored
        cls(1, 0, 1, 0);
        car(4'b1010);
        idle(SETTLE + 1);
        chk("high_fee", Fee0, 200);
        coin(8'd100);
        coin(8'd50);
        chk("high_gate_closed", Gate0, 0);
        coin(8'd75);
        chk("high_gate_open", Gate0, 1);
        chk("high_change", Change0, 25);
        car(4'b0101);
        coin(8'd100);
        chk("high_change_hold", Change0, 25);
        idle(GATE_CYCLES - 2);
        chk("high_count", Cnt0, 2);
        chk("high_attr_hold", {AWD0, ARH0, ALN0, AHT0}, 4'b1010);
        chk("high_busy", Busy0, 0);
        idle(2);

        // Err with High also set -> alarm, coins ignored, Clear returns to IDLE
        clear_pulse();
        cls(1, 0, 0, 1);
        car(4'b0011);
        idle(SETTLE + 1);
        chk("err_alarm", Alarm0, 1);
        chk("err_fee", Fee0, 0);
        coin(8'd200);
        idle(2);
        chk("err_alarm_hold", Alarm0, 1);
        chk("err_gate", Gate0, 0);
        clear_pulse();
        chk("err_cleared", Alarm0, 0);
        chk("err_count", Cnt0, 2);

        // No class asserted -> alarm
        cls(0, 0, 0, 0);
        car(4'b1111);
        idle(SETTLE + 1);
        chk("nocls_alarm", Alarm0, 1);
        clear_pulse();
        idle(1);

        // Med timeout: one coin, then 64 coinless cycles
        cls(0, 1, 0, 0);
        car(4'b0110);
        idle(SETTLE + 1);
        chk("med_fee", Fee0, 100);
        coin(8'd25);
        idle(TIMEOUT - 1);
        chk("tout_not_yet", Alarm0, 0);
        idle(1);
        chk("tout_alarm", Alarm0, 1);
        chk("tout_gate", Gate0, 0);
        chk("tout_fee", Fee0, 0);
        clear_pulse();
        idle(1);

        // Coin on the timeout cycle wins; Med beats Low
        cls(0, 1, 1, 0);
        car(4'b1001);
        idle(SETTLE + 1);
        idle(TIMEOUT - 1);
        coin(8'd25);
        chk("coinwins_alarm", Alarm0, 0);
        coin(8'd75);
        chk("coinwins_gate", Gate0, 1);
        chk("coinwins_change", Change0, 0);
        idle(GATE_CYCLES);
        chk("coinwins_count", Cnt0, 3);
        idle(1);

        // Asynchronous reset in the middle of PAY
        cls(0, 0, 1, 0);
        car(4'b0111);
        idle(SETTLE + 1);
        coin(8'd25);
        RST = 1'b1;
        #1;
        chk("rst_busy", Busy0, 0);
        chk("rst_fee", Fee0, 0);
        chk("rst_count", Cnt0, 0);
        chk("rst_attr", {AWD0, ARH0, ALN0, AHT0}, 4'b0000);
        chk("rst_alarm", Alarm0, 0);
        chk("rst_count_w2", Cnt1, 0);
        step();
        RST = 1'b0;
        idle(2);

        // Four paid cars: 2-bit counter wraps to 0
        for (int k = 0; k < 4; k++) begin
            car(4'(k));
            idle(SETTLE + 1);
            coin(8'd60);
            chk("wrap_change", Change0, 10);
            idle(GATE_CYCLES);
        end
        chk("wrap_count16", Cnt0, 4);
        chk("wrap_count2", Cnt1, 0);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : p_watchdog
        #200000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
